seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning consecutive stable sampled cycles required before a digit is captured (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port seg, input, 7, segment lines, active-high, bit6..0 = a,b,c,d,e,f,g.
REQ-005 SHALL have port an, input, 4, digit select, active-high, one-hot; bit0 = least significant digit.
REQ-006 SHALL have port bcd, output, 16, four decoded digits; nibble k = digit k.
REQ-007 SHALL have port digit_err, output, 4, bit k set = digit k pattern illegal in last frame.
REQ-008 SHALL have port frame_valid, output, 1, one-cycle pulse when bcd/digit_err update.

Function
REQ-009 SHALL register seg and an in one input stage; all decisions use the registered copies.
REQ-010 SHALL decode patterns: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9 (hex, bit6=a).
REQ-011 SHALL decode 7'h00 as blank: code 4'hF, error clear.
REQ-012 SHALL decode any other pattern as code 4'hE with error set.
REQ-013 SHALL run FSM states IDLE, SETTLE, HELD.
REQ-014 IDLE: registered an not one-hot; stability counter held at 0; no capture.
REQ-015 IDLE->SETTLE when registered an becomes one-hot; counter loads 1.
REQ-016 SETTLE: counter increments each cycle registered seg and an equal previous registered values; any change restarts (counter=1, or IDLE if an not one-hot).
REQ-017 SETTLE->HELD when counter reaches SETTLE_CYCLES; that cycle the decoded code/error are written to the shadow slot of the selected digit and its seen bit set.
REQ-018 HELD: no further capture; any change of seg or an returns to SETTLE (or IDLE if an not one-hot); exactly one capture per dwell.
REQ-019 Recapture of a digit already seen in the current frame SHALL overwrite its shadow slot.
REQ-020 When the seen mask becomes 4'b1111, the next cycle SHALL copy shadow to bcd/digit_err, pulse frame_valid high for one cycle, and clear the mask.
REQ-021 Capture latency: seg/an change to shadow write = 1 (input stage) + SETTLE_CYCLES cycles; fourth capture to frame_valid = 1 cycle.
REQ-022 A capture coinciding with the mask-clear cycle SHALL count toward the new frame.
REQ-023 bcd and digit_err SHALL hold their values between frame_valid pulses.
REQ-024 Counter SHALL saturate at SETTLE_CYCLES; no wrap.

Reset
REQ-025 On rst_n low: bcd=16'hFFFF, digit_err=0, frame_valid=0, state IDLE, counter 0, mask 0, shadow all 4'hF, input stage 0.
REQ-026 Reset mid-frame SHALL discard partial captures; first frame_valid after release needs four fresh captures.

Structure
REQ-027 Package seg7_pkg SHALL hold the ten pattern constants, BLANK_CODE=4'hF, ERR_CODE=4'hE, FSM state typedef.
REQ-028 Combinational sub-module seg7_to_bcd SHALL implement REQ-010..012 (seg in; code, err out), shared with the existing encoder bench as a golden model.

Verification
REQ-029 Scan 1,2,3,4 (an 0001..1000, 7E-style patterns 30,6D,79,33), dwell 8 cycles each -> one frame_valid, bcd=16'h4321, digit_err=0.
REQ-030 Dwell of SETTLE_CYCLES-1 cycles on digit 2 then move on -> no capture, no frame_valid until digit 2 revisited.
REQ-031 Digit 3 pattern 7'h01 (g only) -> bcd[15:12]=4'hE, digit_err=4'b1000.
REQ-032 an=4'b0011 for 20 cycles -> FSM stays IDLE, no capture, outputs unchanged.
REQ-033 Digit 0 shown blank (7'h00), others 5,0,9 -> bcd=16'h905F... digit order per REQ-006, digit_err=0.
REQ-034 rst_n low after three captures, then full scan 9,8,7,6 -> single frame_valid, bcd=16'h6789.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns,
// special digit codes and the scan FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ERR_CODE   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to digit-code decoder; blank maps to
// BLANK_CODE, anything unrecognised to ERR_CODE with err set.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = ERR_CODE;
    err  = 1'b1;
    case (seg)
      SEG_0:     begin code = 4'd0;       err = 1'b0; end
      SEG_1:     begin code = 4'd1;       err = 1'b0; end
      SEG_2:     begin code = 4'd2;       err = 1'b0; end
      SEG_3:     begin code = 4'd3;       err = 1'b0; end
      SEG_4:     begin code = 4'd4;       err = 1'b0; end
      SEG_5:     begin code = 4'd5;       err = 1'b0; end
      SEG_6:     begin code = 4'd6;       err = 1'b0; end
      SEG_7:     begin code = 4'd7;       err = 1'b0; end
      SEG_8:     begin code = 4'd8;       err = 1'b0; end
      SEG_9:     begin code = 4'd9;       err = 1'b0; end
      SEG_BLANK: begin code = BLANK_CODE; err = 1'b0; end
      default:   begin code = ERR_CODE;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers four BCD digits from a multiplexed seven-segment scan: each digit
// is captured once per dwell after its pattern has been stable long enough.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd,
  output logic [3:0]  digit_err,
  output logic        frame_valid
);

  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);

  logic [6:0]  seg_p0, seg_p1;
  logic [3:0]  an_p0, an_p1;
  logic        one_hot, changed;
  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic        capture;
  logic [3:0]  code;
  logic        err;
  logic [3:0]  mask, mask_next;
  logic        frame_done;
  logic [15:0] shadow_bcd;
  logic [3:0]  shadow_err;

  // Stage p0 registers the pins; p1 holds the previous sample for the stability compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p0 <= '0;
      an_p0  <= '0;
      seg_p1 <= '0;
      an_p1  <= '0;
    end else begin
      seg_p0 <= seg;
      an_p0  <= an;
      seg_p1 <= seg_p0;
      an_p1  <= an_p0;
    end
  end

  assign one_hot = (an_p0 != 4'd0) && ((an_p0 & (an_p0 - 4'd1)) == 4'd0);
  assign changed = (seg_p0 != seg_p1) || (an_p0 != an_p1);

  seg7_to_bcd u_dec (
    .seg  (seg_p0),
    .code (code),
    .err  (err)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = 8'd0;
        if (one_hot) begin
          state_next = ST_SETTLE;
          cnt_next   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!one_hot) begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end else if (changed) begin
          cnt_next = 8'd1;
        end else if (cnt < SETTLE_MAX) begin
          cnt_next = cnt + 8'd1;
        end
      end
      ST_HELD: begin
        if (!one_hot) begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end else if (changed) begin
          state_next = ST_SETTLE;
          cnt_next   = 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
    // Reaching the threshold (including on the first stable cycle) captures at once
    if (state_next == ST_SETTLE && cnt_next == SETTLE_MAX) begin
      state_next = ST_HELD;
      capture    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A capture landing on the publish cycle seeds the next frame's mask
  assign frame_done = (mask == 4'hF);
  assign mask_next  = (frame_done ? 4'h0 : mask) | (capture ? an_p0 : 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask        <= 4'h0;
      shadow_bcd  <= {4{BLANK_CODE}};
      shadow_err  <= 4'h0;
      bcd         <= {4{BLANK_CODE}};
      digit_err   <= 4'h0;
      frame_valid <= 1'b0;
    end else begin
      mask        <= mask_next;
      frame_valid <= frame_done;
      for (int k = 0; k < 4; k++) begin
        if (capture && an_p0[k]) begin
          shadow_bcd[4*k +: 4] <= code;
          shadow_err[k]        <= err;
        end
      end
      if (frame_done) begin
        bcd       <= shadow_bcd;
        digit_err <= shadow_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: table of full-frame scans plus
// hand-written sequences for dwell timing, idle selects, recapture and reset.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic [3:0]  digit_err;
  logic        frame_valid;

  seg7_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .bcd         (bcd),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   fv_count = 0;
  int   fv_double = 0;
  logic fv_prev = 1'b0;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count++;
      if (fv_prev) fv_double++;
    end
    fv_prev = frame_valid;
  end

  typedef struct {
    logic [27:0] pats;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_err;
  } frame_t;

  frame_t vec [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic show(input int d, input logic [6:0] p, input int dwell);
    an  = 4'(1 << d);
    seg = p;
    repeat (dwell) @(negedge clk);
  endtask

  initial begin
    int base;
    int wait_cnt;

    vec[0] = '{pats: {7'h33, 7'h79, 7'h6D, 7'h30}, exp_bcd: 16'h4321, exp_err: 4'b0000};
    vec[1] = '{pats: {7'h7B, 7'h7E, 7'h5B, 7'h00}, exp_bcd: 16'h905F, exp_err: 4'b0000};
    vec[2] = '{pats: {7'h01, 7'h6D, 7'h30, 7'h7E}, exp_bcd: 16'hE210, exp_err: 4'b1000};
    vec[3] = '{pats: {7'h7E, 7'h7F, 7'h70, 7'h5F}, exp_bcd: 16'h0876, exp_err: 4'b0000};
    vec[4] = '{pats: {7'h33, 7'h3F, 7'h49, 7'h7F}, exp_bcd: 16'h4EE8, exp_err: 4'b0110};

    rst_n = 1'b0;
    seg   = 7'h00;
    an    = 4'h0;
    repeat (2) @(negedge clk);
    check("reset_bcd", 32'(bcd), 32'hFFFF);
    check("reset_err", 32'(digit_err), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // capture-to-publish latency on the fourth digit
    base = fv_count;
    show(0, 7'h7B, 8);
    show(1, 7'h7F, 8);
    show(2, 7'h70, 8);
    an = 4'b1000;
    seg = 7'h5F;
    wait_cnt = 0;
    while (!frame_valid && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("latency_cycles", 32'(wait_cnt), 32'(S + 2));
    repeat (3) @(negedge clk);
    check("latency_fv_count", 32'(fv_count - base), 32'd1);
    check("latency_bcd", 32'(bcd), 32'h6789);

    for (int i = 0; i < 5; i++) begin
      base = fv_count;
      for (int d = 0; d < 4; d++) show(d, vec[i].pats[7*d +: 7], 8);
      check($sformatf("frame%0d_fv", i), 32'(fv_count - base), 32'd1);
      check($sformatf("frame%0d_bcd", i), 32'(bcd), 32'(vec[i].exp_bcd));
      check($sformatf("frame%0d_err", i), 32'(digit_err), 32'(vec[i].exp_err));
    end

    // too-short dwell on digit 2 must not capture
    base = fv_count;
    show(0, 7'h30, 8);
    show(1, 7'h6D, 8);
    show(2, 7'h79, S - 1);
    show(3, 7'h33, 8);
    check("short_dwell_no_fv", 32'(fv_count - base), 32'd0);
    check("short_dwell_bcd_held", 32'(bcd), 32'h4EE8);
    check("short_dwell_err_held", 32'(digit_err), 32'b0110);
    show(2, 7'h79, S + 1);
    repeat (2) @(negedge clk);
    check("revisit_fv", 32'(fv_count - base), 32'd1);
    check("revisit_bcd", 32'(bcd), 32'h4321);
    check("revisit_err", 32'(digit_err), 32'h0);

    // two selects active at once is not a digit
    base = fv_count;
    an  = 4'b0011;
    seg = 7'h33;
    repeat (20) @(negedge clk);
    check("multi_an_no_fv", 32'(fv_count - base), 32'd0);
    show(1, 7'h5F, 8);
    show(2, 7'h70, 8);
    show(3, 7'h7F, 8);
    check("multi_an_no_capture", 32'(fv_count - base), 32'd0);
    check("multi_an_bcd_held", 32'(bcd), 32'h4321);
    show(0, 7'h5B, 8);
    check("multi_an_frame_fv", 32'(fv_count - base), 32'd1);
    check("multi_an_frame_bcd", 32'(bcd), 32'h8765);

    // pattern change on the same select recaptures that digit
    base = fv_count;
    show(0, 7'h30, 8);
    show(0, 7'h5B, 8);
    show(1, 7'h6D, 8);
    show(2, 7'h79, 8);
    show(3, 7'h33, 8);
    check("recapture_fv", 32'(fv_count - base), 32'd1);
    check("recapture_bcd", 32'(bcd), 32'h4325);

    // reset after three captures discards the partial frame
    show(0, 7'h30, 8);
    show(1, 7'h30, 8);
    show(2, 7'h30, 8);
    #2 rst_n = 1'b0;
    an  = 4'h0;
    seg = 7'h00;
    @(negedge clk);
    check("midreset_bcd", 32'(bcd), 32'hFFFF);
    check("midreset_err", 32'(digit_err), 32'h0);
    check("midreset_fv", 32'(frame_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    base = fv_count;
    show(3, 7'h5F, 8);
    show(2, 7'h70, 8);
    show(1, 7'h7F, 8);
    show(0, 7'h7B, 8);
    check("post_reset_fv", 32'(fv_count - base), 32'd1);
    check("post_reset_bcd", 32'(bcd), 32'h6789);
    check("post_reset_err", 32'(digit_err), 32'h0);

    check("fv_single_cycle", 32'(fv_double), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
